seg_scan_driver: RTL and testbench

Eight-digit seven-segment scan driver that sits directly downstream of the free-running 3-bit digit counter on the Nexys4 board. It consumes the counter's `select` digit index, holds a tear-free double-buffered 32-bit hex value, and drives the active-low anode, segment and decimal-point pins. Each digit switch is preceded by a programmable blanking interval, which prevents ghosting between digits.

---
 rtl/seg_scan_driver_if.sv | 23 ++
 rtl/seg_scan_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// Load-side bus of seg_scan_driver: a valid/ready handshake carrying the next
// 32-bit hex display value and its eight decimal points.
// The master offers data; the slave (the scan driver) returns load_ready.
interface seg_scan_driver_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_dp;

    modport master (
        output load_valid,
        output load_data,
        output load_dp,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_dp,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: eight-digit seven-segment scan driver.
// Follows an external free-running 3-bit digit index (select), inserts
// BLANK_CYCLES all-off cycles before every digit switch to stop ghosting, and
// shows a double-buffered 32-bit hex value. A loaded value sits in a shadow
// register and is promoted to the display register only when the scan wraps
// to digit 0, so a frame never mixes old and new digits.
// All outputs (an, seg, dp are active-low) come straight from flops.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank digits above the
// most-significant non-zero nibble (digit 0 is always shown).
module seg_scan_driver #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [2:0]        select,
    seg_scan_driver_if.slave  load,
    output logic [7:0]        an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame_start
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [2:0]  sel_q;
    logic [2:0]  sel_prev_q;     // sel_q one cycle ago
    logic        sel_change;
    logic        frame_boundary;

    logic [31:0] shadow_data_q;
    logic [7:0]  shadow_dp_q;
    logic        shadow_full_q;
    logic [31:0] disp_data_q;
    logic [7:0]  disp_dp_q;
    logic        load_ready_q;
    logic        frame_start_q;
    logic        accept;
    logic        copy;

    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic [7:0]  an_show;
    logic [3:0]  cur_nib;
    logic        digit_blank;

    genvar gi;

    // Standard hex glyphs, {g,f,e,d,c,b,a} active-low, lowercase b and d
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    assign sel_change     = (sel_q != sel_prev_q);
    assign frame_boundary = sel_change && (sel_q == 3'd0);
    // load_ready is only high while the shadow is empty, so accept and copy
    // are mutually exclusive; an accept on a boundary waits for the next frame
    assign accept         = load.load_valid && load_ready_q;
    assign copy           = frame_boundary && shadow_full_q;
    assign load.load_ready = load_ready_q;

    // Register the digit index and keep its previous value for change detection
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sel_q      <= 3'd0;
            sel_prev_q <= 3'd0;
        end else begin
            sel_q      <= select;
            sel_prev_q <= sel_q;
        end
    end

    // Blank/show state register and blank down-counter
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_BLANK;
            bcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next state: any digit change (re)starts the blank, which then runs out
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        if (sel_change) begin
            state_d = ST_BLANK;
            bcnt_d  = BLANK_INIT;
        end else if (state_q == ST_BLANK) begin
            if (bcnt_q != 4'd0) begin
                bcnt_d = bcnt_q - 4'd1;
            end else begin
                state_d = ST_SHOW;
            end
        end
    end

    // Shadow buffer: filled by an accepted load, emptied by the frame copy
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shadow_data_q <= 32'd0;
            shadow_dp_q   <= 8'd0;
            shadow_full_q <= 1'b0;
        end else if (accept) begin
            shadow_data_q <= load.load_data;
            shadow_dp_q   <= load.load_dp;
            shadow_full_q <= 1'b1;
        end else if (copy) begin
            shadow_full_q <= 1'b0;
        end
    end

    // Display register reloads at the frame boundary; ready lags the copy by one cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            disp_data_q   <= 32'd0;
            disp_dp_q     <= 8'd0;
            frame_start_q <= 1'b0;
            load_ready_q  <= 1'b1;
        end else begin
            if (copy) begin
                disp_data_q <= shadow_data_q;
                disp_dp_q   <= shadow_dp_q;
            end
            frame_start_q <= copy;
            load_ready_q  <= !(shadow_full_q || accept);
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] shadow_nz;
    logic [7:0] lz_blank_d;
    logic [7:0] lz_blank_q;
    logic       nz_seen;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_shadow_nz
            assign shadow_nz[gi] = |shadow_data_q[4*gi +: 4];
        end
    endgenerate

    // Blank every digit above the highest non-zero nibble; digit 0 never blanks
    always_comb begin
        lz_blank_d = 8'd0;
        nz_seen    = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            nz_seen       = nz_seen | shadow_nz[i];
            lz_blank_d[i] = ~nz_seen;
        end
    end

    // Mask is captured together with the display value, so decode stays one lookup
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lz_blank_q <= 8'hFE;
        end else if (copy) begin
            lz_blank_q <= lz_blank_d;
        end
    end

    assign digit_blank = lz_blank_q[sel_q];
`else
    assign digit_blank = 1'b0;
`endif

    generate
        for (gi = 0; gi < 8; gi++) begin : g_anode
            assign an_show[gi] = (sel_q != 3'(gi));
        end
    endgenerate

    assign cur_nib = disp_data_q[{sel_q, 2'b00} +: 4];

    // Registered pin drivers, computed from the next state so blanking starts immediately
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else if (state_d == ST_SHOW) begin
            an_q  <= an_show;
            seg_q <= digit_blank ? 7'h7F : hex_glyph(cur_nib);
            dp_q  <= ~disp_dp_q[sel_q];
        end else begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver. Each digit visit pushes the
// expected glyph/anode/dp onto a scoreboard queue when select is driven; the
// entry is popped and compared when the digit should appear after the blank.
// A small model tracks the shadow and display values independently.
module tb_seg_scan_driver;

    localparam int BLANK = 4;
    localparam int HOLD  = 20;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [2:0] select = 3'd0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    seg_scan_driver_if lif ();

    seg_scan_driver #(.BLANK_CYCLES(BLANK)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .select      (select),
        .load        (lif),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 aclk = ~aclk;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [31:0] disp_m = 32'd0;
    logic [7:0]  disp_dp_m = 8'd0;
    logic [31:0] shadow_m = 32'd0;
    logic [7:0]  shadow_dp_m = 8'd0;
    logic        shadow_full_m = 1'b0;
    logic [2:0]  cur_sel = 3'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input logic [31:0] v, input int d);
        logic [3:0] nib;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic [31:0] upper;
        upper = v >> (4 * d);
        if (d != 0 && upper == 32'd0) return 7'h7F;
`endif
        nib = v[4*d +: 4];
        return glyph_tbl[nib];
    endfunction

    task automatic pop_check(input int d);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL sb_underflow: got empty queue expected entry for digit %0d", d);
        end else begin
            e = sb_q.pop_front();
            chk("show_an", an, e.an);
            chk("show_seg", seg, e.seg);
            chk("show_dp", dp, e.dp);
            $display("digit %0d: an=%h seg=%h dp=%b", d, an, seg, dp);
        end
    endtask

    function automatic exp_t make_exp(input int d);
        exp_t e;
        e.an  = ~(8'b1 << d);
        e.seg = exp_glyph(disp_m, d);
        e.dp  = ~disp_dp_m[d];
        return e;
    endfunction

    // Move to digit d, check the blank window, the frame copy and the shown glyph
    task automatic show_digit(input int d);
        logic copy;
        exp_t e;
        copy = (d == 0) && (cur_sel != 3'd0) && shadow_full_m;
        if (copy) begin
            disp_m    = shadow_m;
            disp_dp_m = shadow_dp_m;
        end
        e = make_exp(d);
        sb_q.push_back(e);
        @(negedge aclk);
        select  = 3'(d);
        cur_sel = 3'(d);
        @(posedge aclk);
        for (int i = 1; i <= BLANK; i++) begin
            @(posedge aclk);
            #1;
            chk("blank_an", an, 8'hFF);
            if (i == 1) begin
                chk("blank_seg", seg, 7'h7F);
                chk("frame_start", frame_start, copy);
                chk("ready_in_blank", load_ready_now(), !shadow_full_m);
            end
            if (i == 2 && copy) begin
                chk("frame_start_end", frame_start, 1'b0);
                chk("ready_rise", load_ready_now(), 1'b1);
                shadow_full_m = 1'b0;
            end
        end
        @(posedge aclk);
        #1;
        pop_check(d);
        repeat (HOLD - BLANK - 2) @(posedge aclk);
        #1;
        chk("hold_an", an, e.an);
    endtask

    function automatic logic load_ready_now();
        return lif.load_ready;
    endfunction

    task automatic do_load(input logic [31:0] v, input logic [7:0] p);
        @(negedge aclk);
        lif.load_valid = 1'b1;
        lif.load_data  = v;
        lif.load_dp    = p;
        chk("ready_before_load", lif.load_ready, 1'b1);
        @(posedge aclk);
        #1;
        lif.load_valid = 1'b0;
        chk("ready_after_accept", lif.load_ready, 1'b0);
        shadow_m      = v;
        shadow_dp_m   = p;
        shadow_full_m = 1'b1;
        $display("load %h dp=%h while digit %0d", v, p, cur_sel);
    endtask

    // Change 2->3, then 3->4 two cycles into the blank: digit 3 must never light
    task automatic restart_blank();
        exp_t e;
        e = make_exp(4);
        sb_q.push_back(e);
        @(negedge aclk);
        select = 3'd3;
        @(posedge aclk);
        repeat (2) begin
            @(posedge aclk);
            #1;
            chk("restart_an_a", an, 8'hFF);
        end
        @(negedge aclk);
        select  = 3'd4;
        cur_sel = 3'd4;
        repeat (1 + BLANK) begin
            @(posedge aclk);
            #1;
            chk("restart_an_b", an, 8'hFF);
        end
        @(posedge aclk);
        #1;
        pop_check(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, an, 8'hFF);
        chk({tag, "_seg"}, seg, 7'h7F);
        chk({tag, "_dp"}, dp, 1'b1);
        chk({tag, "_ready"}, lif.load_ready, 1'b1);
        chk({tag, "_fs"}, frame_start, 1'b0);
    endtask

    task automatic release_and_check();
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("release_an", an, 8'hFE);
        chk("release_seg", seg, exp_glyph(disp_m, 0));
        chk("release_dp", dp, 1'b1);
        $display("reset released: an=%h seg=%h", an, seg);
    endtask

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = 32'd0;
        lif.load_dp    = 8'd0;

        // Reset held with select toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            select = select + 3'd1;
            @(posedge aclk);
            #1;
            check_reset_outputs("reset_hold");
        end
        @(negedge aclk);
        select = 3'd0;
        cur_sel = 3'd0;
        release_and_check();

        // Load and sweep: old (zero) frame, then the new value after the wrap
        do_load(32'h1234ABCD, 8'h10);
        for (int d = 1; d < 8; d++) show_digit(d);
        for (int d = 0; d < 8; d++) show_digit(d);

        // Mid-frame load while digit 3 shows
        for (int d = 0; d < 4; d++) show_digit(d);
        do_load(32'h00000005, 8'h00);
        for (int d = 4; d < 8; d++) show_digit(d);
        for (int d = 0; d < 3; d++) show_digit(d);

        // Blank restart
        restart_blank();
        show_digit(5);

        // Asynchronous reset in the middle of SHOW
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        select        = 3'd0;
        cur_sel       = 3'd0;
        disp_m        = 32'd0;
        disp_dp_m     = 8'd0;
        shadow_full_m = 1'b0;
        repeat (2) @(posedge aclk);
        release_and_check();
        show_digit(5);

        // Value with leading zeros
        do_load(32'h00000A07, 8'h01);
        show_digit(6);
        show_digit(7);
        for (int d = 0; d < 8; d++) show_digit(d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
